tile_write_scheduler: RTL and testbench

- Sequences writes into the write-side bank of the ping-pong 32x24 tile map: 8-bit tile codes, 10-bit address = row*32 + col.
- On each bank swap, it first clears the whole map to a background tile.
- It then arbitrates round-robin between NUM_REQ game-logic requesters, each writing single tiles through a req/ack handshake.
- Sits between game logic and the memory controller's write port (addrWrite/dataWrite), gating writes with wr_en.

---
 rtl/tile_write_scheduler.sv | 161 ++++++++++++++++
 tb/tb_tile_write_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/tile_write_scheduler.sv
// Write sequencer for the write-side bank of the ping-pong 32x24 tile map.
// Clears the bank to CLEAR_TILE on every frame_start, then round-robin arbitrates single-tile writes.
module tile_write_scheduler #(
    parameter int         NUM_REQ    = 4,
    parameter logic [7:0] CLEAR_TILE = 8'h00,
    parameter int         MAP_CELLS  = 768
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [5*NUM_REQ-1:0] req_x,
    input  logic [5*NUM_REQ-1:0] req_y,
    input  logic [8*NUM_REQ-1:0] req_tile,
    output logic [NUM_REQ-1:0]   ack,
    output logic [9:0]           addrWrite,
    output logic [7:0]           dataWrite,
    output logic                 wr_en,
    output logic                 busy,
    output logic                 oob,
    output logic                 overrun
);

    localparam int         PTR_W     = $clog2(NUM_REQ);
    localparam logic [4:0] MAP_ROWS  = 5'd24;
    localparam logic [9:0] LAST_ADDR = 10'(MAP_CELLS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ARB   = 2'd2
    } stateT;

    stateT             stateQ, stateD;
    logic [9:0]        clearCnt, cntD;
    logic [PTR_W-1:0]  rrPtr, rrD;

    logic [NUM_REQ-1:0] ackD;
    logic [9:0]         addrD;
    logic [7:0]         dataD;
    logic               wrD, busyD, oobD, overrunD;

    // Round-robin search; the requester being acked this cycle is masked so a held req is not granted twice.
    logic [NUM_REQ-1:0] eligible;
    logic               grantFound;
    logic [PTR_W-1:0]   grantIdx;
    logic [4:0]         grantX, grantY;
    logic [7:0]         grantTile;

    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default before any branch, otherwise a latch is inferred.
        eligible   = req & ~ack;
        grantFound = 1'b0;
        grantIdx   = '0;
        grantX     = '0;
        grantY     = '0;
        grantTile  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rrPtr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grantFound && eligible[idx]) begin
                grantFound = 1'b1;
                grantIdx   = PTR_W'(idx);
                grantX     = req_x[5*idx +: 5];
                grantY     = req_y[5*idx +: 5];
                grantTile  = req_tile[8*idx +: 8];
            end
        end
    end

    // clearCnt always holds the address currently presented on addrWrite during CLEAR.
    always_comb begin
        logic startClear;
        stateD     = stateQ;
        cntD       = clearCnt;
        rrD        = rrPtr;
        ackD       = '0;
        addrD      = '0;
        dataD      = '0;
        wrD        = 1'b0;
        busyD      = 1'b0;
        oobD       = 1'b0;
        overrunD   = 1'b0;
        startClear = 1'b0;

        unique case (stateQ)
            IDLE: begin
                if (frame_start) startClear = 1'b1;
            end
            CLEAR: begin
                if (frame_start) begin
                    startClear = 1'b1;
                    overrunD   = 1'b1;
                end else if (clearCnt == LAST_ADDR) begin
                    stateD = ARB;
                end else begin
                    cntD  = clearCnt + 10'd1;
                    addrD = clearCnt + 10'd1;
                    dataD = CLEAR_TILE;
                    wrD   = 1'b1;
                    busyD = 1'b1;
                end
            end
            ARB: begin
                if (frame_start) begin
                    startClear = 1'b1;
                end else if (grantFound) begin
                    ackD[grantIdx] = 1'b1;
                    addrD          = {grantY, 5'b0} + {5'b0, grantX};
                    dataD          = grantTile;
                    // Off-map rows are acked so the requester moves on, but never written.
                    if (grantY >= MAP_ROWS) oobD = 1'b1;
                    else                    wrD  = 1'b1;
                    rrD = (int'(grantIdx) == NUM_REQ - 1) ? '0 : grantIdx + PTR_W'(1);
                end
            end
            default: stateD = IDLE;
        endcase

        // A bank swap overrides any grant decided on the same edge.
        if (startClear) begin
            stateD = CLEAR;
            cntD   = '0;
            ackD   = '0;
            addrD  = '0;
            dataD  = CLEAR_TILE;
            wrD    = 1'b1;
            busyD  = 1'b1;
            oobD   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= IDLE;
            clearCnt  <= '0;
            rrPtr     <= '0;
            ack       <= '0;
            addrWrite <= '0;
            dataWrite <= '0;
            wr_en     <= 1'b0;
            busy      <= 1'b0;
            oob       <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            stateQ    <= stateD;
            clearCnt  <= cntD;
            rrPtr     <= rrD;
            ack       <= ackD;
            addrWrite <= addrD;
            dataWrite <= dataD;
            wr_en     <= wrD;
            busy      <= busyD;
            oob       <= oobD;
            overrun   <= overrunD;
        end
    end

endmodule

// File: tb/tb_tile_write_scheduler.sv
// Directed bench for tile_write_scheduler: clear sequencing, round-robin order, oob drop,
// overrun, frame_start cancelling a grant, and asynchronous reset.
module tb_tile_write_scheduler;

    localparam int NUM_REQ = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 frame_start;
    logic [NUM_REQ-1:0]   req;
    logic [5*NUM_REQ-1:0] req_x;
    logic [5*NUM_REQ-1:0] req_y;
    logic [8*NUM_REQ-1:0] req_tile;
    logic [NUM_REQ-1:0]   ack;
    logic [9:0]           addrWrite;
    logic [7:0]           dataWrite;
    logic                 wr_en;
    logic                 busy;
    logic                 oob;
    logic                 overrun;

    int nVec  = 0;
    int nMiss = 0;

    tile_write_scheduler #(.NUM_REQ(NUM_REQ), .CLEAR_TILE(8'h00), .MAP_CELLS(768)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .req(req), .req_x(req_x), .req_y(req_y), .req_tile(req_tile),
        .ack(ack), .addrWrite(addrWrite), .dataWrite(dataWrite),
        .wr_en(wr_en), .busy(busy), .oob(oob), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMiss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int i, input logic [4:0] x, input logic [4:0] y, input logic [7:0] t);
        req_x[5*i +: 5]    = x;
        req_y[5*i +: 5]    = y;
        req_tile[8*i +: 8] = t;
    endtask

    // Walks a clear run from address firstAddr to 767, checking every cycle; caller is in the firstAddr cycle.
    task automatic runClear(input string tag, input int firstAddr);
        int bad = 0;
        for (int a = firstAddr; a < 768; a++) begin
            if (addrWrite !== 10'(a) || wr_en !== 1'b1 || busy !== 1'b1 ||
                dataWrite !== 8'h00 || ack !== '0 || oob !== 1'b0)
                bad++;
            if (a == 767) check({tag, "_last_addr"}, addrWrite, 32'd767);
            tick();
        end
        check({tag, "_seq_errors"}, bad, 0);
        check({tag, "_done_busy"}, busy, 0);
        check({tag, "_done_wr_en"}, wr_en, 0);
        check({tag, "_done_ack"}, ack, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        req         = '0;
        req_x       = '0;
        req_y       = '0;
        req_tile    = '0;
        #12;
        check("rst_ack", ack, 0);
        check("rst_outputs", {22'd0, addrWrite, dataWrite, wr_en, busy, oob, overrun}, 0);
        rst_n = 1'b1;
        tick();

        // IDLE ignores requests.
        setReq(3, 5'd1, 5'd1, 8'hEE);
        req = 4'b1000;
        tick(); tick(); tick();
        check("idle_no_ack", ack, 0);
        check("idle_no_wr", wr_en, 0);

        // All four requesters pending through the clear: y=1, x=i, tile=0x10+i.
        for (int i = 0; i < NUM_REQ; i++) setReq(i, 5'(i), 5'd1, 8'(8'h10 + i));
        req = 4'b1111;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("clear_first_addr", addrWrite, 0);
        runClear("clear1", 0);
        tick();

        // Round robin 0,1,2,3,0,... one write per cycle.
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rr_ack_%0d", k), ack, 32'(4'b0001 << (k % 4)));
            check($sformatf("rr_addr_%0d", k), addrWrite, 32'(32 + k % 4));
            check($sformatf("rr_data_%0d", k), dataWrite, 32'(8'h10 + k % 4));
            check($sformatf("rr_wr_%0d", k), wr_en, 1);
            if (k == 7) req = '0;
            tick();
        end
        check("no_req_ack", ack, 0);
        check("no_req_wr", wr_en, 0);
        check("no_req_addr", addrWrite, 0);

        // Single requester 2: acked every other cycle.
        setReq(2, 5'd5, 5'd23, 8'hA7);
        req = 4'b0100;
        tick();
        check("single_ack_a", ack, 32'b0100);
        check("single_addr_a", addrWrite, 741);
        check("single_data_a", dataWrite, 32'hA7);
        check("single_wr_a", wr_en, 1);
        tick();
        check("single_gap_ack", ack, 0);
        check("single_gap_wr", wr_en, 0);
        tick();
        check("single_ack_b", ack, 32'b0100);
        check("single_addr_b", addrWrite, 741);
        req = '0;
        tick();
        check("single_drop_ack", ack, 0);

        // Off-map row: acked, flagged, not written.
        setReq(0, 5'd0, 5'd24, 8'h55);
        req = 4'b0001;
        tick();
        check("oob_ack", ack, 32'b0001);
        check("oob_flag", oob, 1);
        check("oob_wr_en", wr_en, 0);
        req = '0;
        tick();
        check("oob_clear", oob, 0);

        // frame_start on the same edge as a pending grant: grant cancelled, clear starts.
        setReq(1, 5'd3, 5'd2, 8'h66);
        req = 4'b0010;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("cancel_ack", ack, 0);
        check("cancel_busy", busy, 1);
        check("cancel_addr", addrWrite, 0);
        check("cancel_overrun", overrun, 0);
        for (int a = 0; a < 400; a++) tick();
        check("mid_clear_addr", addrWrite, 400);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("overrun_pulse", overrun, 1);
        check("overrun_addr", addrWrite, 0);
        check("overrun_busy", busy, 1);
        tick();
        check("overrun_drop", overrun, 0);
        runClear("clear2", 1);
        tick();
        check("deferred_ack", ack, 32'b0010);
        check("deferred_addr", addrWrite, 67);
        check("deferred_data", dataWrite, 32'h66);
        check("deferred_wr", wr_en, 1);
        req = '0;
        tick();

        // Asynchronous reset mid-clear.
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int a = 0; a < 10; a++) tick();
        check("pre_reset_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {18'd0, ack, addrWrite, dataWrite, wr_en, busy, oob, overrun}, 0);
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);
        tick();
        check("post_rst_idle_wr", wr_en, 0);
        check("post_rst_idle_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
